// File: rtl/alu_operand_stage_pkg.sv
// rtl/alu_operand_stage_pkg.sv - shared ALU op codes and register-update actions for the ID/EX stage
package alu_operand_stage_pkg;

  localparam int unsigned ALU_ADD = 0;

  typedef enum logic [1:0] {
    UPD_HOLD,
    UPD_FLUSH,
    UPD_BUBBLE,
    UPD_CAPTURE
  } upd_e;

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - one-operand forwarding mux; EX/MEM beats MEM/WB, x0 is never forwarded
module fwd_mux #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] rs_addr,
  input  logic [XLEN-1:0] reg_value,
  input  logic [RA_W-1:0] exmem_rd_addr,
  input  logic            exmem_reg_write,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [RA_W-1:0] memwb_rd_addr,
  input  logic            memwb_reg_write,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] fwd_value
);

  always_comb begin
    fwd_value = reg_value;
    if (rs_addr != '0) begin
      if (exmem_reg_write && (exmem_rd_addr == rs_addr)) begin
        fwd_value = exmem_result;
      end else if (memwb_reg_write && (memwb_rd_addr == rs_addr)) begin
        fwd_value = memwb_result;
      end
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ID/EX register with operand forwarding and load-use bubble insertion
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int SEL_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ID_VALID,
  input  logic [XLEN-1:0]  ID_PC,
  input  logic [XLEN-1:0]  ID_RS1_DATA,
  input  logic [XLEN-1:0]  ID_RS2_DATA,
  input  logic [XLEN-1:0]  ID_IMM,
  input  logic [RA_W-1:0]  ID_RS1_ADDR,
  input  logic [RA_W-1:0]  ID_RS2_ADDR,
  input  logic [RA_W-1:0]  ID_RD_ADDR,
  input  logic [SEL_W-1:0] ID_SELECT,
  input  logic             ID_OP1_SEL,
  input  logic             ID_OP2_SEL,
  input  logic             ID_REG_WRITE,
  input  logic             ID_MEM_READ,
  input  logic [RA_W-1:0]  EXMEM_RD_ADDR,
  input  logic             EXMEM_REG_WRITE,
  input  logic [XLEN-1:0]  EXMEM_RESULT,
  input  logic [RA_W-1:0]  MEMWB_RD_ADDR,
  input  logic             MEMWB_REG_WRITE,
  input  logic [XLEN-1:0]  MEMWB_RESULT,
  input  logic             STALL_IN,
  input  logic             FLUSH,
  output logic [XLEN-1:0]  DATA1,
  output logic [XLEN-1:0]  DATA2,
  output logic [SEL_W-1:0] SELECT,
  output logic             EX_VALID,
  output logic [RA_W-1:0]  EX_RD_ADDR,
  output logic             EX_REG_WRITE,
  output logic             EX_MEM_READ,
  output logic [XLEN-1:0]  EX_STORE_DATA,
  output logic             HAZARD_STALL,
  output logic [CNT_W-1:0] BUBBLE_CNT
);

  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [RA_W-1:0] ex_rs1_addr, ex_rs2_addr;
  logic            ex_op1_sel, ex_op2_sel;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;
  logic            m1, m2;
  upd_e            upd;

  assign m1 = !ID_OP1_SEL && (ID_RS1_ADDR == EX_RD_ADDR);
  assign m2 = (ID_RS2_ADDR == EX_RD_ADDR);
  assign HAZARD_STALL = ID_VALID && EX_VALID && EX_MEM_READ && (EX_RD_ADDR != '0) && (m1 || m2);

  always_comb begin
    upd = UPD_CAPTURE;
    if (STALL_IN)          upd = UPD_HOLD;
    else if (FLUSH)        upd = UPD_FLUSH;
    else if (HAZARD_STALL) upd = UPD_BUBBLE;
  end

  // Bubbles still load the ID operand fields; only the control bits are killed.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1_addr <= '0;
      ex_rs2_addr <= '0;
      EX_RD_ADDR  <= '0;
      ex_op1_sel  <= 1'b0;
      ex_op2_sel  <= 1'b0;
    end else if (upd != UPD_HOLD) begin
      ex_pc       <= ID_PC;
      ex_rs1_data <= ID_RS1_DATA;
      ex_rs2_data <= ID_RS2_DATA;
      ex_imm      <= ID_IMM;
      ex_rs1_addr <= ID_RS1_ADDR;
      ex_rs2_addr <= ID_RS2_ADDR;
      EX_RD_ADDR  <= ID_RD_ADDR;
      ex_op1_sel  <= ID_OP1_SEL;
      ex_op2_sel  <= ID_OP2_SEL;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      EX_VALID     <= 1'b0;
      EX_REG_WRITE <= 1'b0;
      EX_MEM_READ  <= 1'b0;
      SELECT       <= SEL_W'(ALU_ADD);
      BUBBLE_CNT   <= '0;
    end else begin
      case (upd)
        UPD_FLUSH, UPD_BUBBLE: begin
          EX_VALID     <= 1'b0;
          EX_REG_WRITE <= 1'b0;
          EX_MEM_READ  <= 1'b0;
          SELECT       <= SEL_W'(ALU_ADD);
          if ((upd == UPD_BUBBLE) && (BUBBLE_CNT != '1)) begin
            BUBBLE_CNT <= BUBBLE_CNT + CNT_W'(1);
          end
        end
        UPD_CAPTURE: begin
          EX_VALID     <= ID_VALID;
          EX_REG_WRITE <= ID_VALID && ID_REG_WRITE;
          EX_MEM_READ  <= ID_VALID && ID_MEM_READ;
          SELECT       <= ID_SELECT;
        end
        default: ;
      endcase
    end
  end

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
    .rs_addr         (ex_rs1_addr),
    .reg_value       (ex_rs1_data),
    .exmem_rd_addr   (EXMEM_RD_ADDR),
    .exmem_reg_write (EXMEM_REG_WRITE),
    .exmem_result    (EXMEM_RESULT),
    .memwb_rd_addr   (MEMWB_RD_ADDR),
    .memwb_reg_write (MEMWB_REG_WRITE),
    .memwb_result    (MEMWB_RESULT),
    .fwd_value       (fwd_rs1)
  );

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
    .rs_addr         (ex_rs2_addr),
    .reg_value       (ex_rs2_data),
    .exmem_rd_addr   (EXMEM_RD_ADDR),
    .exmem_reg_write (EXMEM_REG_WRITE),
    .exmem_result    (EXMEM_RESULT),
    .memwb_rd_addr   (MEMWB_RD_ADDR),
    .memwb_reg_write (MEMWB_REG_WRITE),
    .memwb_result    (MEMWB_RESULT),
    .fwd_value       (fwd_rs2)
  );

  assign DATA1         = ex_op1_sel ? ex_pc  : fwd_rs1;
  assign DATA2         = ex_op2_sel ? ex_imm : fwd_rs2;
  assign EX_STORE_DATA = fwd_rs2;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - directed bench with a cycle-level reference model for alu_operand_stage
module tb_alu_operand_stage;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ID_VALID;
  logic [31:0] ID_PC, ID_RS1_DATA, ID_RS2_DATA, ID_IMM;
  logic [4:0]  ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR, ID_SELECT;
  logic        ID_OP1_SEL, ID_OP2_SEL, ID_REG_WRITE, ID_MEM_READ;
  logic [4:0]  EXMEM_RD_ADDR, MEMWB_RD_ADDR;
  logic        EXMEM_REG_WRITE, MEMWB_REG_WRITE;
  logic [31:0] EXMEM_RESULT, MEMWB_RESULT;
  logic        STALL_IN, FLUSH;
  logic [31:0] DATA1, DATA2, EX_STORE_DATA;
  logic [4:0]  SELECT, EX_RD_ADDR;
  logic        EX_VALID, EX_REG_WRITE, EX_MEM_READ, HAZARD_STALL;
  logic [3:0]  BUBBLE_CNT;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 0;

  localparam logic [4:0] ADD = 5'd0;

  alu_operand_stage #(.XLEN(32), .RA_W(5), .SEL_W(5), .CNT_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .ID_VALID(ID_VALID), .ID_PC(ID_PC),
    .ID_RS1_DATA(ID_RS1_DATA), .ID_RS2_DATA(ID_RS2_DATA), .ID_IMM(ID_IMM),
    .ID_RS1_ADDR(ID_RS1_ADDR), .ID_RS2_ADDR(ID_RS2_ADDR), .ID_RD_ADDR(ID_RD_ADDR),
    .ID_SELECT(ID_SELECT), .ID_OP1_SEL(ID_OP1_SEL), .ID_OP2_SEL(ID_OP2_SEL),
    .ID_REG_WRITE(ID_REG_WRITE), .ID_MEM_READ(ID_MEM_READ),
    .EXMEM_RD_ADDR(EXMEM_RD_ADDR), .EXMEM_REG_WRITE(EXMEM_REG_WRITE), .EXMEM_RESULT(EXMEM_RESULT),
    .MEMWB_RD_ADDR(MEMWB_RD_ADDR), .MEMWB_REG_WRITE(MEMWB_REG_WRITE), .MEMWB_RESULT(MEMWB_RESULT),
    .STALL_IN(STALL_IN), .FLUSH(FLUSH), .DATA1(DATA1), .DATA2(DATA2), .SELECT(SELECT),
    .EX_VALID(EX_VALID), .EX_RD_ADDR(EX_RD_ADDR), .EX_REG_WRITE(EX_REG_WRITE),
    .EX_MEM_READ(EX_MEM_READ), .EX_STORE_DATA(EX_STORE_DATA), .HAZARD_STALL(HAZARD_STALL),
    .BUBBLE_CNT(BUBBLE_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what the stage holds, in instruction-level terms.
  bit          m_valid = 0, m_op1 = 0, m_op2 = 0, m_rw = 0, m_mr = 0;
  logic [31:0] m_pc = 0, m_rs1d = 0, m_rs2d = 0, m_imm = 0;
  logic [4:0]  m_rs1 = 0, m_rs2 = 0, m_rd = 0, m_sel = 0;
  int          m_bubbles = 0;

  function automatic bit model_hazard();
    bit uses_rd;
    uses_rd = (!ID_OP1_SEL && ID_RS1_ADDR == m_rd) || (ID_RS2_ADDR == m_rd);
    return ID_VALID && m_valid && m_mr && (m_rd != 0) && uses_rd;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] regval);
    if (a == 0) return regval;
    if (EXMEM_REG_WRITE && EXMEM_RD_ADDR == a) return EXMEM_RESULT;
    if (MEMWB_REG_WRITE && MEMWB_RD_ADDR == a) return MEMWB_RESULT;
    return regval;
  endfunction

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_valid = 0; m_op1 = 0; m_op2 = 0; m_rw = 0; m_mr = 0;
      m_pc = 0; m_rs1d = 0; m_rs2d = 0; m_imm = 0;
      m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_sel = ADD; m_bubbles = 0;
    end else if (!STALL_IN) begin
      bit kill;
      bit haz;
      haz  = model_hazard();
      kill = FLUSH || haz;
      if (!FLUSH && haz && m_bubbles < 15) m_bubbles++;
      m_pc = ID_PC; m_rs1d = ID_RS1_DATA; m_rs2d = ID_RS2_DATA; m_imm = ID_IMM;
      m_rs1 = ID_RS1_ADDR; m_rs2 = ID_RS2_ADDR; m_rd = ID_RD_ADDR;
      m_op1 = ID_OP1_SEL; m_op2 = ID_OP2_SEL;
      m_valid = !kill && ID_VALID;
      m_rw    = m_valid && ID_REG_WRITE;
      m_mr    = m_valid && ID_MEM_READ;
      m_sel   = kill ? ADD : ID_SELECT;
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("ex_valid", 32'(EX_VALID), 32'(m_valid));
      chk("ex_reg_write", 32'(EX_REG_WRITE), 32'(m_rw));
      chk("ex_mem_read", 32'(EX_MEM_READ), 32'(m_mr));
      chk("select", 32'(SELECT), 32'(m_sel));
      chk("hazard_stall", 32'(HAZARD_STALL), 32'(model_hazard()));
      chk("bubble_cnt", 32'(BUBBLE_CNT), 32'(m_bubbles));
      if (m_valid || !RESET) begin
        chk("data1", DATA1, m_op1 ? m_pc : fwd(m_rs1, m_rs1d));
        chk("data2", DATA2, m_op2 ? m_imm : fwd(m_rs2, m_rs2d));
        chk("store_data", EX_STORE_DATA, fwd(m_rs2, m_rs2d));
        chk("ex_rd_addr", 32'(EX_RD_ADDR), 32'(m_rd));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic idle_id();
    ID_VALID = 0; ID_PC = 0; ID_RS1_DATA = 0; ID_RS2_DATA = 0; ID_IMM = 0;
    ID_RS1_ADDR = 0; ID_RS2_ADDR = 0; ID_RD_ADDR = 0; ID_SELECT = 0;
    ID_OP1_SEL = 0; ID_OP2_SEL = 0; ID_REG_WRITE = 0; ID_MEM_READ = 0;
  endtask

  task automatic idle_fwd();
    EXMEM_RD_ADDR = 0; EXMEM_REG_WRITE = 0; EXMEM_RESULT = 0;
    MEMWB_RD_ADDR = 0; MEMWB_REG_WRITE = 0; MEMWB_RESULT = 0;
  endtask

  task automatic issue(input logic [31:0] pc, rs1d, rs2d, imm,
                       input logic [4:0] rs1, rs2, rd, sel,
                       input logic op1, op2, rw, mr);
    ID_VALID = 1; ID_PC = pc; ID_RS1_DATA = rs1d; ID_RS2_DATA = rs2d; ID_IMM = imm;
    ID_RS1_ADDR = rs1; ID_RS2_ADDR = rs2; ID_RD_ADDR = rd; ID_SELECT = sel;
    ID_OP1_SEL = op1; ID_OP2_SEL = op2; ID_REG_WRITE = rw; ID_MEM_READ = mr;
  endtask

  initial begin
    RESET = 0; STALL_IN = 0; FLUSH = 0;
    idle_id(); idle_fwd();
    repeat (3) tick();
    cmp_en = 1;
    tick();
    RESET = 1;

    // 1. reset state after release, nothing issued
    tick(); #1;
    chk("t1_ex_valid", 32'(EX_VALID), 0);
    chk("t1_select", 32'(SELECT), 32'(ADD));
    chk("t1_data1", DATA1, 0);
    chk("t1_data2", DATA2, 0);
    chk("t1_bubble_cnt", 32'(BUBBLE_CNT), 0);

    // 2. plain ADD, then PC/IMM operand selection
    issue(32'h100, 5, 10, 0, 5'd1, 5'd2, 5'd4, ADD, 0, 0, 1, 0);
    tick(); #1;
    chk("t2_data1", DATA1, 5);
    chk("t2_data2", DATA2, 10);
    chk("t2_alu_sum", DATA1 + DATA2, 15);
    issue(32'h200, 7, 8, 32'h55, 5'd1, 5'd2, 5'd4, 5'd3, 1, 1, 1, 0);
    tick(); idle_id(); #1;
    chk("t2_pc_op", DATA1, 32'h200);
    chk("t2_imm_op", DATA2, 32'h55);
    chk("t2_store", EX_STORE_DATA, 8);
    chk("t2_select", 32'(SELECT), 3);

    // 3. forwarding priority and x0
    issue(32'h300, 1, 2, 0, 5'd3, 5'd9, 5'd10, 5'd2, 0, 0, 1, 0);
    tick(); idle_id();
    EXMEM_RD_ADDR = 3; EXMEM_REG_WRITE = 1; EXMEM_RESULT = 100;
    MEMWB_RD_ADDR = 3; MEMWB_REG_WRITE = 1; MEMWB_RESULT = 200;
    #1 chk("t3_exmem_wins", DATA1, 100);
    EXMEM_REG_WRITE = 0;
    #1 chk("t3_memwb", DATA1, 200);
    idle_fwd();
    issue(32'h304, 0, 2, 0, 5'd0, 5'd9, 5'd10, 5'd2, 0, 0, 1, 0);
    tick(); idle_id();
    EXMEM_RD_ADDR = 0; EXMEM_REG_WRITE = 1; EXMEM_RESULT = 100;
    MEMWB_RD_ADDR = 0; MEMWB_REG_WRITE = 1; MEMWB_RESULT = 200;
    #1 chk("t3_x0", DATA1, 0);
    tick(); idle_fwd();

    // 4. load-use hazard on rs2
    issue(32'h400, 0, 0, 4, 5'd1, 5'd0, 5'd7, ADD, 0, 1, 1, 1);
    tick();
    issue(32'h404, 3, 32'hdead, 0, 5'd2, 5'd7, 5'd8, 5'd6, 0, 0, 1, 0);
    #1 chk("t4_hazard", 32'(HAZARD_STALL), 1);
    tick(); #1;
    chk("t4_bubble_valid", 32'(EX_VALID), 0);
    chk("t4_bubble_cnt", 32'(BUBBLE_CNT), 1);
    chk("t4_hazard_drop", 32'(HAZARD_STALL), 0);
    tick(); idle_id();
    MEMWB_RD_ADDR = 7; MEMWB_REG_WRITE = 1; MEMWB_RESULT = 32'h77;
    #1;
    chk("t4_valid", 32'(EX_VALID), 1);
    chk("t4_data2_fwd", DATA2, 32'h77);
    chk("t4_store_fwd", EX_STORE_DATA, 32'h77);
    chk("t4_data1", DATA1, 3);
    tick(); idle_fwd();

    // 5. stall beats flush
    issue(32'h500, 32'h11, 32'h22, 0, 5'd11, 5'd12, 5'd13, 5'd4, 0, 0, 1, 0);
    tick();
    issue(32'h504, 32'h99, 32'h98, 0, 5'd14, 5'd15, 5'd16, 5'd5, 0, 0, 1, 0);
    STALL_IN = 1; FLUSH = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("t5_frozen_valid", 32'(EX_VALID), 1);
      chk("t5_frozen_data1", DATA1, 32'h11);
      chk("t5_frozen_select", 32'(SELECT), 4);
    end
    STALL_IN = 0;
    tick(); #1;
    chk("t5_flush_valid", 32'(EX_VALID), 0);
    chk("t5_flush_rw", 32'(EX_REG_WRITE), 0);
    FLUSH = 0;

    // 6. counter saturation, then asynchronous reset mid-run
    for (int i = 0; i < 18; i++) begin
      issue(32'h600, 0, 0, 8, 5'd1, 5'd0, 5'd5, ADD, 0, 1, 1, 1);
      tick();
      issue(32'h604, 1, 2, 0, 5'd5, 5'd6, 5'd6, 5'd1, 0, 0, 1, 0);
      tick();
    end
    #1 chk("t6_saturated", 32'(BUBBLE_CNT), 15);
    issue(32'h700, 32'h12, 32'h34, 0, 5'd1, 5'd2, 5'd3, 5'd7, 0, 0, 1, 0);
    tick();
    RESET = 0;
    #1;
    chk("t6_rst_valid", 32'(EX_VALID), 0);
    chk("t6_rst_cnt", 32'(BUBBLE_CNT), 0);
    chk("t6_rst_select", 32'(SELECT), 32'(ADD));
    chk("t6_rst_data1", DATA1, 0);
    chk("t6_rst_data2", DATA2, 0);
    tick();
    RESET = 1;
    idle_id();
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
